// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM states, BCD limit
// and active-low seven-segment codes (g..a, bit 0 = segment a).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch chain; q_next is exposed so the display
// register can be loaded on the same edge as the digit itself.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_in,
  input  logic       clear,
  output logic [3:0] q,
  output logic [3:0] q_next,
  output logic       carry_out
);

  assign carry_out = inc_in & (q == BCD_MAX);

  always_comb begin
    q_next = q;
    if (clear)
      q_next = 4'd0;
    else if (inc_in)
      q_next = (q == BCD_MAX) ? 4'd0 : q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      q <= 4'd0;
    else
      q <= q_next;
  end

endmodule

// File: rtl/lap_stopwatch.sv
// N-digit BCD stopwatch with lap freeze, clear-from-pause and sticky overflow.
// Define LAP_STOPWATCH_SEG_EN to add the active-low seg_out decoders.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 10,
  parameter int DIGITS      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  lap_active,
  output logic                  overflow
`ifdef LAP_STOPWATCH_SEG_EN
  ,
  output logic [7*DIGITS-1:0]   seg_out
`endif
);

  localparam int TICKS = CLK_FREQ_HZ / TICK_HZ;
  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  sw_state_e           state;
  logic                ss_prev, lap_prev;
  logic                ss_rise, lap_rise;
  logic                counting, tick, pause_clear;
  logic [CNT_W-1:0]    tick_cnt;
  logic [4*DIGITS-1:0] digits_q, digits_next, lap_q;
  logic [DIGITS:0]     inc;

  // The previous-level registers follow the buttons even during reset, so a
  // button held through reset is seen as already high and does not fire.
  always_ff @(posedge clk) begin
    ss_prev  <= start_stop;
    lap_prev <= lap;
  end

  assign ss_rise     = start_stop & ~ss_prev;
  assign lap_rise    = lap & ~lap_prev;
  assign counting    = (state == RUN) || (state == LAP);
  assign tick        = counting && (tick_cnt == CNT_W'(TICKS - 1));
  assign pause_clear = (state == PAUSE) && lap_rise && !ss_rise;
  assign inc[0]      = tick;

  always_ff @(posedge clk) begin
    if (reset || pause_clear)
      tick_cnt <= '0;
    else if (counting)
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
        .clk       (clk),
        .reset     (reset),
        .inc_in    (inc[k]),
        .clear     (pause_clear),
        .q         (digits_q[4*k +: 4]),
        .q_next    (digits_next[4*k +: 4]),
        .carry_out (inc[k+1])
      );
    end
  endgenerate

  // A carry out of the top digit means every digit was 9 on a tick.
  always_ff @(posedge clk) begin
    if (reset || pause_clear)
      overflow <= 1'b0;
    else if (inc[DIGITS])
      overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      running    <= 1'b0;
      lap_active <= 1'b0;
      lap_q      <= '0;
      bcd_out    <= '0;
    end else begin
      bcd_out <= digits_next;
      case (state)
        IDLE: begin
          if (ss_rise) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (ss_rise) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (lap_rise) begin
            state      <= LAP;
            lap_active <= 1'b1;
            lap_q      <= digits_q;
            bcd_out    <= digits_q;
          end
        end
        LAP: begin
          if (ss_rise) begin
            state      <= PAUSE;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lap_rise) begin
            state      <= RUN;
            lap_active <= 1'b0;
          end else begin
            bcd_out <= lap_q;
          end
        end
        PAUSE: begin
          if (ss_rise) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (lap_rise) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LAP_STOPWATCH_SEG_EN
  generate
    for (genvar s = 0; s < DIGITS; s++) begin : g_seg
      assign seg_out[7*s +: 7] = seg_decode(bcd_out[4*s +: 4]);
    end
  endgenerate
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch: a decimal-arithmetic reference model
// queues the expected outputs per cycle and a monitor compares them.
module tb_lap_stopwatch;

  localparam int CLK_HZ = 100;
  localparam int TCK_HZ = 10;
  localparam int DIG    = 2;
  localparam int TICKS  = CLK_HZ / TCK_HZ;
  localparam int MAXV   = 100;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start_stop = 1'b0;
  logic           lap = 1'b0;
  logic [4*DIG-1:0] bcd_out;
  logic           running, lap_active, overflow;

  always #5 clk = ~clk;

  lap_stopwatch #(
    .CLK_FREQ_HZ (CLK_HZ),
    .TICK_HZ     (TCK_HZ),
    .DIGITS      (DIG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .bcd_out    (bcd_out),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [4*DIG-1:0] bcd;
    logic             run;
    logic             frz;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: elapsed tenths as an integer, not digit registers.
  int m_val = 0, m_sub = 0, m_lapval = 0;
  bit m_active = 0, m_frozen = 0, m_ovf = 0, m_ssp = 0, m_lpp = 0;

  function automatic logic [4*DIG-1:0] to_bcd(input int v);
    logic [4*DIG-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < DIG; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic step(input bit rst, input bit ss, input bit lp);
    bit ssr, lpr;
    int old;
    exp_t e;
    @(negedge clk);
    reset      = rst;
    start_stop = ss;
    lap        = lp;
    ssr   = ss & !m_ssp;
    lpr   = lp & !m_lpp;
    m_ssp = ss;
    m_lpp = lp;
    if (rst) begin
      m_val = 0; m_sub = 0; m_lapval = 0;
      m_active = 0; m_frozen = 0; m_ovf = 0;
    end else begin
      old = m_val;
      if (m_active) begin
        if (m_sub == TICKS - 1) begin
          m_sub = 0;
          m_val = m_val + 1;
          if (m_val == MAXV) begin
            m_val = 0;
            m_ovf = 1;
          end
        end else begin
          m_sub = m_sub + 1;
        end
      end
      if (ssr) begin
        if (m_active) begin
          m_active = 0;
          m_frozen = 0;
        end else begin
          m_active = 1;
        end
      end else if (lpr) begin
        if (m_active) begin
          if (m_frozen) m_frozen = 0;
          else begin
            m_frozen = 1;
            m_lapval = old;
          end
        end else begin
          m_val = 0; m_sub = 0; m_ovf = 0;
        end
      end
    end
    e.bcd = to_bcd(m_frozen ? m_lapval : m_val);
    e.run = m_active;
    e.frz = m_frozen;
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic press_ss();
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic press_lap();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({bcd_out, running, lap_active, overflow} !== e) begin
          bad++;
          if (bad <= 20)
            $display("FAIL cycle_check t=%0t got bcd=%h run=%b lap=%b ovf=%b expected bcd=%h run=%b lap=%b ovf=%b",
                     $time, bcd_out, running, lap_active, overflow, e.bcd, e.run, e.frz, e.ovf);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit ss_lvl, lp_lvl, rst_now;
    repeat (3) step(1, 0, 0);

    // Count through 99 into wrap and overflow.
    press_ss();
    idle(1005);
    // Pause, then clear from pause.
    press_ss();
    idle(5);
    press_lap();
    idle(3);

    // Lap freeze around 23 while the counter keeps running.
    press_ss();
    idle(228);
    press_lap();
    idle(50);
    press_lap();
    idle(10);

    // Partial-tick hold across a pause.
    press_ss();
    press_lap();
    press_ss();
    idle(14);
    press_ss();
    idle(40);
    press_ss();
    idle(12);

    // Simultaneous rises in RUN: start_stop wins.
    step(0, 1, 1);
    step(0, 0, 0);
    idle(5);
    press_ss();
    idle(20);

    // Button held across reset release must not toggle.
    repeat (3) step(1, 1, 0);
    repeat (5) step(0, 1, 0);
    idle(3);

    // Reset in the middle of a run.
    press_ss();
    idle(470);
    step(1, 0, 0);
    idle(5);

    // Randomised button activity.
    ss_lvl = 0;
    lp_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      rst_now = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 24) == 0) ss_lvl = !ss_lvl;
      if ($urandom_range(0, 29) == 0) lp_lvl = !lp_lvl;
      step(rst_now, ss_lvl, lp_lvl);
    end
    idle(3);

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
